// File: rtl/benes_issue.sv
// Issue stage in front of a Benes crossbar: holds the control-word table and keeps
// the shared control vector stable until every earlier vector has left the network.
module benes_issue #(
    parameter int unsigned SIZE     = 32,
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned NCFG     = 4,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned BITWIDTH = (2 * $clog2(SIZE) - 1) * SIZE / 2,
    parameter int unsigned IDW      = (NCFG > 1) ? $clog2(NCFG) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [IDW-1:0]           cfg_addr,
    input  logic [BITWIDTH-1:0]      cfg_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDW-1:0]           in_cfg_id,
    input  logic [SIZE*DWIDTH-1:0]   in_data,
    output logic [SIZE*DWIDTH-1:0]   bn_in,
    output logic [BITWIDTH-1:0]      bn_ctrl,
    input  logic [SIZE*DWIDTH-1:0]   bn_out,
    output logic                     out_valid,
    output logic [IDW-1:0]           out_cfg_id,
    output logic [SIZE*DWIDTH-1:0]   out_data
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    logic [BITWIDTH-1:0]           table_q [NCFG];
    logic [IDW-1:0]                cur_id_q;
    logic                          loaded_q;
    logic                          stale_q;
    logic                          stale_d;
    logic [SIZE*DWIDTH-1:0]        bn_in_q;
    logic [BITWIDTH-1:0]           bn_ctrl_q;
    logic [PIPE_LAT:0]             occ_q;
    logic [PIPE_LAT:0]             occ_d;
    logic [PIPE_LAT:0][IDW-1:0]    id_q;
    logic [PIPE_LAT:0][IDW-1:0]    id_d;

    logic   busy;
    logic   same;
    logic   accept;
    state_e state;

    // busy looks one cycle ahead: vectors in occ[PIPE_LAT] leave before the next edge.
    if (PIPE_LAT == 0) begin : g_nolat
        always_comb begin
            busy  = 1'b0;
            occ_d = accept;
            id_d  = accept ? in_cfg_id : '0;
        end
    end else begin : g_lat
        always_comb begin
            busy  = |occ_q[PIPE_LAT-1:0];
            occ_d = {occ_q[PIPE_LAT-1:0], accept};
            id_d  = {id_q[PIPE_LAT-1:0], (accept ? in_cfg_id : {IDW{1'b0}})};
        end
    end

    always_comb begin
        same = loaded_q && !stale_q && (in_cfg_id == cur_id_q);
        if (!loaded_q) begin
            state = IDLE;
        end else if (!same && busy) begin
            state = DRAIN;
        end else begin
            state = RUN;
        end
        in_ready = (state != DRAIN);
        accept   = in_valid && in_ready;
    end

    // A write landing on the id being (re)loaded this cycle marks it stale straight away.
    always_comb begin
        if (accept && !same) begin
            stale_d = cfg_we && (cfg_addr == in_cfg_id);
        end else begin
            stale_d = stale_q || (cfg_we && loaded_q && (cfg_addr == cur_id_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned e = 0; e < NCFG; e++) begin
                table_q[e] <= '0;
            end
            cur_id_q  <= '0;
            loaded_q  <= 1'b0;
            stale_q   <= 1'b0;
            bn_in_q   <= '0;
            bn_ctrl_q <= '0;
            occ_q     <= '0;
            id_q      <= '0;
        end else begin
            if (cfg_we) begin
                table_q[cfg_addr] <= cfg_wdata;
            end
            occ_q   <= occ_d;
            id_q    <= id_d;
            stale_q <= stale_d;
            if (accept) begin
                bn_in_q <= in_data;
                if (!same) begin
                    bn_ctrl_q <= table_q[in_cfg_id];
                    cur_id_q  <= in_cfg_id;
                    loaded_q  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bn_in      = bn_in_q;
        bn_ctrl    = bn_ctrl_q;
        out_valid  = occ_q[PIPE_LAT];
        out_cfg_id = id_q[PIPE_LAT];
        out_data   = bn_out;
    end

endmodule

// File: tb/tb_benes_issue.sv
// Directed bench for benes_issue: two instances (PIPE_LAT=2 and 0) each feeding a
// butterfly/inverse-butterfly network model that applies the live control vector per stage.
module tb_benes_issue;

    localparam int unsigned N    = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned LOGN = 3;
    localparam int unsigned BW   = 20;
    localparam int unsigned IW   = 2;

    typedef logic [N*DW-1:0] vec_t;
    typedef logic [BW-1:0]   ctl_t;

    // stage0 all-swap -> port i takes i^4; stage1 -> i^2; all stages -> i^1
    localparam ctl_t W1 = 20'h0000F;
    localparam ctl_t W2 = 20'h000F0;
    localparam ctl_t W3 = 20'hFFFFF;
    localparam ctl_t WI = 20'h00000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          cfg_we_a, cfg_we_b;
    logic [IW-1:0] cfg_addr_a, cfg_addr_b;
    ctl_t          cfg_wdata_a, cfg_wdata_b;
    logic          in_valid_a, in_valid_b;
    logic          in_ready_a, in_ready_b;
    logic [IW-1:0] in_cfg_id_a, in_cfg_id_b;
    vec_t          in_data_a, in_data_b;
    vec_t          bn_in_a, bn_in_b;
    ctl_t          bn_ctrl_a, bn_ctrl_b;
    vec_t          bn_out_a, bn_out_b;
    logic          out_valid_a, out_valid_b;
    logic [IW-1:0] out_cfg_id_a, out_cfg_id_b;
    vec_t          out_data_a, out_data_b;

    benes_issue #(.SIZE(N), .DWIDTH(DW), .NCFG(4), .PIPE_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we_a), .cfg_addr(cfg_addr_a), .cfg_wdata(cfg_wdata_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_cfg_id(in_cfg_id_a), .in_data(in_data_a),
        .bn_in(bn_in_a), .bn_ctrl(bn_ctrl_a), .bn_out(bn_out_a), .out_valid(out_valid_a),
        .out_cfg_id(out_cfg_id_a), .out_data(out_data_a)
    );

    benes_issue #(.SIZE(N), .DWIDTH(DW), .NCFG(4), .PIPE_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b), .cfg_wdata(cfg_wdata_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_cfg_id(in_cfg_id_b), .in_data(in_data_b),
        .bn_in(bn_in_b), .bn_ctrl(bn_ctrl_b), .bn_out(bn_out_b), .out_valid(out_valid_b),
        .out_cfg_id(out_cfg_id_b), .out_data(out_data_b)
    );

    function automatic vec_t stage(input vec_t v, input ctl_t c, input int s);
        vec_t r;
        int   b, lo, hi;
        r = v;
        b = (s < int'(LOGN)) ? int'(LOGN) - 1 - s : s - int'(LOGN) + 1;
        for (int j = 0; j < int'(N / 2); j++) begin
            lo = ((j >> b) << (b + 1)) | (j & ((1 << b) - 1));
            hi = lo | (1 << b);
            if (c[s * int'(N / 2) + j]) begin
                r[lo*DW +: DW] = v[hi*DW +: DW];
                r[hi*DW +: DW] = v[lo*DW +: DW];
            end
        end
        return r;
    endfunction

    function automatic vec_t mkvec(input logic [7:0] base);
        vec_t r;
        for (int i = 0; i < int'(N); i++) r[i*DW +: DW] = base + 8'(i);
        return r;
    endfunction

    function automatic vec_t xperm(input vec_t v, input int k);
        vec_t r;
        for (int i = 0; i < int'(N); i++) r[i*DW +: DW] = v[(i ^ k)*DW +: DW];
        return r;
    endfunction

    // network with registers after stages 1 and 3, all stages sharing the live control
    vec_t a_s1, a_r1, a_s2, a_r2;
    always_comb a_s1 = stage(stage(bn_in_a, bn_ctrl_a, 0), bn_ctrl_a, 1);
    always_ff @(posedge clk) a_r1 <= a_s1;
    always_comb a_s2 = stage(stage(a_r1, bn_ctrl_a, 2), bn_ctrl_a, 3);
    always_ff @(posedge clk) a_r2 <= a_s2;
    always_comb bn_out_a = stage(a_r2, bn_ctrl_a, 4);

    always_comb bn_out_b = stage(stage(stage(stage(stage(bn_in_b, bn_ctrl_b, 0),
                           bn_ctrl_b, 1), bn_ctrl_b, 2), bn_ctrl_b, 3), bn_ctrl_b, 4);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_we_a = 1'b0; cfg_addr_a = '0; cfg_wdata_a = '0;
        in_valid_a = 1'b0; in_cfg_id_a = '0; in_data_a = '0;
        cfg_we_b = 1'b0; cfg_addr_b = '0; cfg_wdata_b = '0;
        in_valid_b = 1'b0; in_cfg_id_b = '0; in_data_b = '0;
        tick();
        tick();
        chk("rst_ready_a", 64'(in_ready_a), 64'd1);
        chk("rst_bn_in_a", 64'(bn_in_a), 64'd0);
        chk("rst_bn_ctrl_a", 64'(bn_ctrl_a), 64'd0);
        chk("rst_valid_a", 64'(out_valid_a), 64'd0);
        chk("rst_id_a", 64'(out_cfg_id_a), 64'd0);
        chk("rst_ready_b", 64'(in_ready_b), 64'd1);
        chk("rst_valid_b", 64'(out_valid_b), 64'd0);
        rst = 1'b0;

        cfg_we_a = 1'b1; cfg_addr_a = 2'd1; cfg_wdata_a = W1;
        tick();
        cfg_addr_a = 2'd2; cfg_wdata_a = W2;
        tick();
        cfg_we_a = 1'b0;

        // four back-to-back id1 vectors, outputs three cycles after each accept
        for (int k = 0; k < 8; k++) begin
            in_valid_a  = (k < 4);
            in_cfg_id_a = 2'd1;
            in_data_a   = mkvec(8'(16 * (k + 1)));
            #1;
            if (k < 4) chk("t1_ready", 64'(in_ready_a), 64'd1);
            tick();
            if (k < 4) begin
                chk("t1_bn_in", 64'(bn_in_a), 64'(mkvec(8'(16 * (k + 1)))));
                chk("t1_bn_ctrl", 64'(bn_ctrl_a), 64'(W1));
            end
            chk("t1_valid", 64'(out_valid_a), 64'((k >= 2) && (k <= 5)));
            if (k >= 2 && k <= 5) begin
                chk("t1_data", 64'(out_data_a), 64'(xperm(mkvec(8'(16 * (k - 1))), 4)));
                chk("t1_id", 64'(out_cfg_id_a), 64'd1);
            end
        end

        // id1 then id2: two stall cycles, control switches after id1 leaves
        in_valid_a = 1'b1; in_cfg_id_a = 2'd1; in_data_a = mkvec(8'h80);
        #1 chk("t2_ready0", 64'(in_ready_a), 64'd1);
        tick();
        in_cfg_id_a = 2'd2; in_data_a = mkvec(8'h90);
        #1 chk("t2_stall1", 64'(in_ready_a), 64'd0);
        tick();
        chk("t2_stall2", 64'(in_ready_a), 64'd0);
        tick();
        chk("t2_ctrl_hold", 64'(bn_ctrl_a), 64'(W1));
        chk("t2_valid1", 64'(out_valid_a), 64'd1);
        chk("t2_data1", 64'(out_data_a), 64'(xperm(mkvec(8'h80), 4)));
        chk("t2_id1", 64'(out_cfg_id_a), 64'd1);
        #1 chk("t2_ready_again", 64'(in_ready_a), 64'd1);
        tick();
        in_valid_a = 1'b0;
        chk("t2_ctrl_w2", 64'(bn_ctrl_a), 64'(W2));
        chk("t2_bn_in", 64'(bn_in_a), 64'(mkvec(8'h90)));
        chk("t2_gap", 64'(out_valid_a), 64'd0);
        tick();
        tick();
        chk("t2_valid2", 64'(out_valid_a), 64'd1);
        chk("t2_data2", 64'(out_data_a), 64'(xperm(mkvec(8'h90), 2)));
        chk("t2_id2", 64'(out_cfg_id_a), 64'd2);

        // rewrite id1 while id1 vectors are in flight
        in_valid_a = 1'b1; in_cfg_id_a = 2'd1; in_data_a = mkvec(8'hA0);
        #1 chk("t3_ready0", 64'(in_ready_a), 64'd1);
        tick();
        chk("t3_ctrl0", 64'(bn_ctrl_a), 64'(W1));
        in_data_a = mkvec(8'hB0);
        cfg_we_a = 1'b1; cfg_addr_a = 2'd1; cfg_wdata_a = W3;
        #1 chk("t3_ready1", 64'(in_ready_a), 64'd1);
        tick();
        cfg_we_a = 1'b0;
        chk("t3_ctrl_old", 64'(bn_ctrl_a), 64'(W1));
        in_data_a = mkvec(8'h00);
        #1 chk("t3_stale_stall1", 64'(in_ready_a), 64'd0);
        tick();
        chk("t3_data_a0", 64'(out_data_a), 64'(xperm(mkvec(8'hA0), 4)));
        #1 chk("t3_stale_stall2", 64'(in_ready_a), 64'd0);
        tick();
        chk("t3_valid_b0", 64'(out_valid_a), 64'd1);
        chk("t3_data_b0", 64'(out_data_a), 64'(xperm(mkvec(8'hB0), 4)));
        #1 chk("t3_ready2", 64'(in_ready_a), 64'd1);
        tick();
        in_valid_a = 1'b0;
        chk("t3_ctrl_new", 64'(bn_ctrl_a), 64'(W3));
        tick();
        tick();
        chk("t3_valid_ones", 64'(out_valid_a), 64'd1);
        chk("t3_data_ones", 64'(out_data_a), 64'h0607040502030001);
        chk("t3_id", 64'(out_cfg_id_a), 64'd1);

        // identity word
        cfg_we_a = 1'b1; cfg_addr_a = 2'd3; cfg_wdata_a = WI;
        tick();
        cfg_we_a = 1'b0;
        in_valid_a = 1'b1; in_cfg_id_a = 2'd3; in_data_a = mkvec(8'h00);
        #1 chk("t4_ready", 64'(in_ready_a), 64'd1);
        tick();
        in_valid_a = 1'b0;
        chk("t4_ctrl", 64'(bn_ctrl_a), 64'(WI));
        tick();
        tick();
        chk("t4_valid", 64'(out_valid_a), 64'd1);
        chk("t4_data", 64'(out_data_a), 64'h0706050403020100);
        chk("t4_id", 64'(out_cfg_id_a), 64'd3);

        // reset with two vectors in flight
        in_valid_a = 1'b1; in_cfg_id_a = 2'd3; in_data_a = mkvec(8'hC0);
        tick();
        in_data_a = mkvec(8'hD0);
        tick();
        in_valid_a = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 64'(out_valid_a), 64'd0);
        chk("t5_ctrl", 64'(bn_ctrl_a), 64'd0);
        chk("t5_bn_in", 64'(bn_in_a), 64'd0);
        chk("t5_ready", 64'(in_ready_a), 64'd1);
        chk("t5_id", 64'(out_cfg_id_a), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_no_stale", 64'(out_valid_a), 64'd0);
        end
        in_valid_a = 1'b1; in_cfg_id_a = 2'd1; in_data_a = mkvec(8'hE0);
        #1 chk("t5_ready2", 64'(in_ready_a), 64'd1);
        tick();
        in_valid_a = 1'b0;
        chk("t5_table_clr", 64'(bn_ctrl_a), 64'd0);

        // zero-latency instance: alternating ids never stall
        cfg_we_b = 1'b1; cfg_addr_b = 2'd1; cfg_wdata_b = W1;
        tick();
        cfg_addr_b = 2'd2; cfg_wdata_b = W2;
        tick();
        cfg_we_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid_b  = 1'b1;
            in_cfg_id_b = (k % 2 == 1) ? 2'd2 : 2'd1;
            in_data_b   = mkvec(8'(16 * k + 32));
            #1 chk("t6_ready", 64'(in_ready_b), 64'd1);
            tick();
            chk("t6_valid", 64'(out_valid_b), 64'd1);
            chk("t6_ctrl", 64'(bn_ctrl_b), (k % 2 == 1) ? 64'(W2) : 64'(W1));
            chk("t6_data", 64'(out_data_b), 64'(xperm(mkvec(8'(16 * k + 32)), (k % 2 == 1) ? 2 : 4)));
            chk("t6_id", 64'(out_cfg_id_b), (k % 2 == 1) ? 64'd2 : 64'd1);
        end
        in_valid_b = 1'b0;
        tick();
        chk("t6_idle", 64'(out_valid_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
